// File: rtl/interlayer_fifo_reader.sv
// interlayer_fifo_reader: drains one cols x rows frame from an FWFT FIFO into a tagged valid/ready stream
module interlayer_fifo_reader #(
    parameter int dw   = 8,
    parameter int aw   = 3,
    parameter int cols = 8,
    parameter int rows = 4,
    parameter int cw   = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic [dw-1:0] fifo_dout_i,
    input  logic [aw:0]   fifo_num_val_i,
    output logic          fifo_r_en_o,
    output logic [dw-1:0] m_data_o,
    output logic          m_sol_o,
    output logic          m_eol_o,
    output logic          m_eof_o,
    output logic          m_valid_o,
    input  logic          m_ready_i
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [cw-1:0] last_col = cw'(cols - 1);
    localparam logic [cw-1:0] last_row = cw'(rows - 1);
    state_t state_q, state_d;
    logic [cw-1:0] col_q, row_q;
    logic [1:0] occ_q;
    logic [dw+2:0] head_q, next_q, pop_word;
    logic pop, accept, tag_eol;
    // buffer entries are {eof, eol, sol, data}; leaving RUN on the eof pop stops further pops
    assign tag_eol = col_q == last_col;
    assign pop_word = {tag_eol & (row_q == last_row), tag_eol, col_q == '0, fifo_dout_i};
    assign pop = (state_q == RUN) & (fifo_num_val_i != '0) & (occ_q != 2'd2);
    assign accept = m_valid_o & m_ready_i;
    assign fifo_r_en_o = pop;
    assign m_valid_o = occ_q != 2'd0;
    assign {m_eof_o, m_eol_o, m_sol_o, m_data_o} = head_q;
    assign busy_o = (state_q == RUN) | (state_q == DRAIN);
    assign done_o = state_q == DONE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = (pop & pop_word[dw+2]) ? DRAIN : RUN;
            DRAIN:   state_d = (accept & m_eof_o) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            occ_q   <= '0;
            head_q  <= '0;
            next_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_i) begin
                col_q <= '0;
                row_q <= '0;
            end else if (pop) begin
                col_q <= tag_eol ? '0 : col_q + 1'b1;
                if (tag_eol) row_q <= row_q + 1'b1;
            end
            occ_q <= occ_q + {1'b0, pop} - {1'b0, accept};
            if ((occ_q == 2'd0 && pop) || (accept && (occ_q == 2'd2 || pop)))
                head_q <= (occ_q == 2'd2) ? next_q : pop_word;
            if (pop && !accept && occ_q == 2'd1) next_q <= pop_word;
        end
    end
endmodule

// File: doc/interlayer_fifo_reader.md
Name: interlayer_fifo_reader

Overview:
- Read-side controller for the inter-layer sync FIFO. Drains exactly one feature-map frame of cols x rows words per start command and presents them to the next layer as a valid/ready stream with sol/eol/eof markers.
- The FIFO is first-word-fall-through: head word is valid on fifo_dout_i whenever fifo_num_val_i != 0; fifo_r_en_o pops it.
- A 2-entry output buffer decouples downstream m_ready_i from fifo_r_en_o, so no combinational path exists between them.

Parameters:
dw, 8, data width (matches FIFO width)
aw, 3, FIFO address width; fifo_num_val_i is aw+1 bits
cols, 8, words per line (>=1)
rows, 4, lines per frame (>=1)
cw, 16, width of column/row counters; must hold cols-1 and rows-1

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  start one frame; honoured only in IDLE
busy_o  out  1  high from the cycle after accepted start until done_o
done_o  out  1  one-cycle pulse after the last (eof) word is accepted downstream
fifo_dout_i  in  dw  FIFO head data (FWFT)
fifo_num_val_i  in  aw+1  readable words in FIFO
fifo_r_en_o  out  1  pop FIFO head this cycle
m_data_o  out  dw  stream data
m_sol_o  out  1  first word of a line
m_eol_o  out  1  last word of a line
m_eof_o  out  1  last word of the frame
m_valid_o  out  1  stream valid
m_ready_i  in  1  stream ready

Behaviour:
- Reset (synchronous, on clk_i) clears everything: state=IDLE, busy_o=0, done_o=0, fifo_r_en_o=0, m_valid_o=0, m_sol_o/m_eol_o/m_eof_o=0, m_data_o=0, col/row counters=0, buffer occupancy=0. Buffer contents are discarded. Reset mid-frame abandons the frame: no further pops and no done_o.
- States:
  - IDLE: start_i -> RUN; counters cleared. start_i in any other state is ignored.
  - RUN: pops until the eof word has been popped, then -> DRAIN.
  - DRAIN: no pops; when the eof word is accepted (m_valid_o & m_ready_i) -> DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o drops the same cycle, -> IDLE.
- Pop rule (fifo_r_en_o is combinational): (state==RUN) & (fifo_num_val_i!=0) & (occ_q<2) & ~eof_popped. occ_q is the registered buffer occupancy (0..2).
- fifo_r_en_o never depends on m_ready_i. It is never asserted when fifo_num_val_i==0, and the total pops per frame are exactly cols*rows.
- Popped word is written into the buffer in the same cycle, together with its tags:
  - sol = (col==0)
  - eol = (col==cols-1)
  - eof = eol & (row==rows-1)
- Counter update: col increments per pop and wraps to 0 after cols-1. row increments on each col wrap.
- Buffer:
  - Output ports come from the buffer head, registered. m_valid_o = (occ_q!=0).
  - Data and tags stay stable while m_valid_o & ~m_ready_i.
  - On a simultaneous pop and accept, occupancy is unchanged and order is preserved.
  - Sustained throughput is 1 word/cycle (steady occ_q=1) when the FIFO is non-empty and m_ready_i=1.
- Latency: a word popped in cycle t appears on m_data_o at t+1.
- Boundaries:
  - fifo_num_val_i going to 0 mid-line stalls pops; counters hold.
  - m_ready_i low for many cycles: occ_q reaches 2 and pops stop.
  - cols=1 gives sol=eol=1 on every word.
  - rows=1, cols=1 gives a single word with sol=eol=eof=1.
  - start_i on the same cycle as done_o is ignored; start_i in the cycle after is accepted.

Test Plan:
- Reset, cols=4, rows=2, FIFO preloaded with 8 words 0x10..0x17, m_ready_i=1, pulse start_i -> 8 consecutive pops, m_data_o 0x10..0x17 on consecutive cycles starting 1 cycle after the first pop. sol on 0x10 and 0x14; eol on 0x13 and 0x17; eof only on 0x17. done_o pulses once, then busy_o=0.
- Same frame, m_ready_i toggling 1,0,1,0 -> no word lost or duplicated, data stable while stalled, occ_q never exceeds 2, fifo_r_en_o never high while occ_q==2.
- FIFO starts empty; one word written every 3 cycles -> fifo_r_en_o only when fifo_num_val_i!=0, words and tags in order, done_o after the 8th word is accepted.
- Assert reset_i after 3 of 8 words are delivered -> next cycle all outputs 0 and no pops. A new start_i then begins at col=0, row=0, with sol on the first word.
- cols=1, rows=1, one word 0xA5 -> single beat with sol=eol=eof=1 and exactly one pop. start_i during busy is ignored: a second frame does not start.
